// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the core's
// memory stage and a line-oriented DRAM controller.
//
// Handshakes:
//   core side: a request is read_enable | write_enable. The cache answers
//   combinationally. miss=1 means the request is not finished yet, and the core
//   holds addr, wdata and the enables stable until miss drops. A request with
//   both enables high is treated as a write.
//   DRAM side: mem_req, mem_we, mem_addr and mem_wdata are registered. They stay
//   stable until a one-cycle mem_ack pulse is sampled in WB or RF. mem_ack in any
//   other state is ignored.
module dcache_dm #(
  parameter int INDEX_BITS = 8,
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  input  logic         read_enable,
  input  logic         write_enable,
  output logic [31:0]  rdata,
  output logic         miss,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  output logic         mem_req,
  output logic         mem_we,
  input  logic         mem_ack
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WB, RF, FILL} state_t;

  state_t state_q, state_d;

  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [31:0]         data_q [LINES][LINE_WORDS];
  logic [127:0]        line_buf;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   addr_tag;
  logic [1:0]            off;
  logic                  unused_byte_bits;
  logic                  req, hit, in_idle, write_hit, read_hit;
  logic [127:0]          old_line;
  logic [31:0]           refill_addr;

  logic         req_d, we_d;
  logic [31:0]  maddr_d;
  logic [127:0] mwdata_d;

  assign idx              = addr[INDEX_BITS+3:4];
  assign addr_tag         = addr[31:INDEX_BITS+4];
  assign off              = addr[3:2];
  assign unused_byte_bits = ^addr[1:0];

  assign req         = read_enable | write_enable;
  assign hit         = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign in_idle     = (state_q == IDLE);
  assign write_hit   = in_idle && hit && write_enable;
  assign read_hit    = in_idle && hit && read_enable;
  assign miss        = req && !(in_idle && hit);
  assign rdata       = read_hit ? data_q[idx][off] : 32'd0;
  assign old_line    = {data_q[idx][3], data_q[idx][2], data_q[idx][1], data_q[idx][0]};
  assign refill_addr = {addr[31:4], 4'b0000};

  // Next state and next values of the registered DRAM-side outputs.
  always_comb begin
    state_d  = state_q;
    req_d    = mem_req;
    we_d     = mem_we;
    maddr_d  = mem_addr;
    mwdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          req_d = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d  = WB;
            we_d     = 1'b1;
            maddr_d  = {tag_q[idx], idx, 4'b0000};
            mwdata_d = old_line;
          end else begin
            state_d = RF;
            we_d    = 1'b0;
            maddr_d = refill_addr;
          end
        end
      end
      WB: begin
        // Request stays up; only direction and address switch to the refill.
        if (mem_ack) begin
          state_d = RF;
          we_d    = 1'b0;
          maddr_d = refill_addr;
        end
      end
      RF: begin
        if (mem_ack) begin
          state_d = FILL;
          req_d   = 1'b0;
        end
      end
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and DRAM-side output registers; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 128'd0;
    end else begin
      state_q   <= state_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= maddr_d;
      mem_wdata <= mwdata_d;
    end
  end

  // Capture the refill line on the acknowledging edge.
  always_ff @(posedge clk) begin
    if (state_q == RF && mem_ack) line_buf <= mem_rdata;
  end

  // Tag, valid and dirty bookkeeping; tags need no reset since valid gates them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == FILL) begin
      tag_q[idx]   <= addr_tag;
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Data array: asynchronous read above, synchronous line fill or word store here.
  always_ff @(posedge clk) begin
    if (rstn && state_q == FILL) begin
      for (int w = 0; w < LINE_WORDS; w++) data_q[idx][w] <= line_buf[32*w +: 32];
    end else if (rstn && write_hit) begin
      data_q[idx][off] <= wdata;
    end
  end

endmodule
